// File: rtl/wb_io_pkg.sv
// Shared register map and bit positions for the Wishbone I/O FIFO slave.
package wb_io_pkg;

   typedef enum logic [1:0] {
      ADR_DATA   = 2'd0,
      ADR_STATUS = 2'd1,
      ADR_CTRL   = 2'd2,
      ADR_COUNT  = 2'd3
   } wb_adr_e;

   localparam int ST_TX_FULL      = 0;
   localparam int ST_TX_EMPTY     = 1;
   localparam int ST_RX_FULL      = 2;
   localparam int ST_RX_EMPTY     = 3;
   localparam int ST_RX_UNDERFLOW = 4;

   localparam int CT_RX_IE = 0;
   localparam int CT_TX_IE = 1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head is a combinational read at rd_ptr.
module sync_fifo #(
   parameter  int DW    = 16,
   parameter  int DEPTH = 8,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [DW-1:0] head,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   localparam int AW = CW - 1;

   logic [DW-1:0] mem [DEPTH];
   logic [CW-1:0] wr_ptr;
   logic [CW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   // Pointers run modulo 2*DEPTH so the MSB tells full apart from empty.
   assign full    = (wr_ptr[CW-1] != rd_ptr[CW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign count   = wr_ptr - rd_ptr;
   assign head    = mem[rd_ptr[AW-1:0]];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + CW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/wb_io_fifo.sv
// Wishbone pipelined I/O slave: CPU writes feed a TX stream, device data lands in an RX FIFO.
module wb_io_fifo
   import wb_io_pkg::*;
#(
   parameter  int DW    = 16,
   parameter  int DEPTH = 8,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wb_cyc_i,
   input  logic          wb_stb_i,
   input  logic          wb_we_i,
   input  logic [1:0]    wb_adr_i,
   input  logic [DW-1:0] wb_dat_i,
   output logic [DW-1:0] wb_dat_o,
   output logic          wb_ack_o,
   output logic          wb_stall_o,
   output logic [DW-1:0] tx_data_o,
   output logic          tx_valid_o,
   input  logic          tx_ready_i,
   input  logic [DW-1:0] rx_data_i,
   input  logic          rx_valid_i,
   output logic          rx_ready_o,
   output logic          irq_o
);

   wb_adr_e       adr;
   logic          req, acc, rd_acc;
   logic          tx_full, tx_empty, rx_full, rx_empty;
   logic [CW-1:0] tx_count, rx_count;
   logic [DW-1:0] rx_head;
   logic          tx_push, tx_pop, rx_push, rx_pop;
   logic          uf_set, uf_clr, ctrl_wr;
   logic          rx_underflow;
   logic [1:0]    ctrl;
   logic [DW-1:0] rd_data;

   assign adr        = wb_adr_e'(wb_adr_i);
   assign req        = wb_cyc_i & wb_stb_i;
   assign wb_stall_o = req & wb_we_i & (adr == ADR_DATA) & tx_full;
   assign acc        = req & ~wb_stall_o;
   assign rd_acc     = acc & ~wb_we_i;

   // Both streams transfer on a cycle where valid and ready are high together;
   // valid never waits on ready, and ready reflects registered FIFO state only.
   assign tx_valid_o = ~tx_empty;
   assign rx_ready_o = ~rx_full;
   assign tx_push    = acc & wb_we_i & (adr == ADR_DATA);
   assign tx_pop     = tx_valid_o & tx_ready_i;
   assign rx_push    = rx_valid_i & rx_ready_o;
   assign rx_pop     = rd_acc & (adr == ADR_DATA) & ~rx_empty;
   assign uf_set     = rd_acc & (adr == ADR_DATA) & rx_empty;
   assign uf_clr     = acc & wb_we_i & (adr == ADR_STATUS) & wb_dat_i[ST_RX_UNDERFLOW];
   assign ctrl_wr    = acc & wb_we_i & (adr == ADR_CTRL);

   sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_tx_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (tx_push),
      .push_data (wb_dat_i),
      .pop       (tx_pop),
      .head      (tx_data_o),
      .full      (tx_full),
      .empty     (tx_empty),
      .count     (tx_count)
   );

   sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_rx_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (rx_push),
      .push_data (rx_data_i),
      .pop       (rx_pop),
      .head      (rx_head),
      .full      (rx_full),
      .empty     (rx_empty),
      .count     (rx_count)
   );

   always_comb begin
      rd_data = '0;
      case (adr)
         ADR_DATA:   rd_data = rx_empty ? '0 : rx_head;
         ADR_STATUS: begin
            rd_data[ST_TX_FULL]      = tx_full;
            rd_data[ST_TX_EMPTY]     = tx_empty;
            rd_data[ST_RX_FULL]      = rx_full;
            rd_data[ST_RX_EMPTY]     = rx_empty;
            rd_data[ST_RX_UNDERFLOW] = rx_underflow;
         end
         ADR_CTRL:   rd_data[1:0] = ctrl;
         ADR_COUNT:  begin
            rd_data[DW/2 +: CW] = tx_count;
            rd_data[0 +: CW]    = rx_count;
         end
         default:    rd_data = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_ack_o     <= 1'b0;
         wb_dat_o     <= '0;
         irq_o        <= 1'b0;
         rx_underflow <= 1'b0;
         ctrl         <= '0;
      end else begin
         wb_ack_o <= acc;
         if (rd_acc) wb_dat_o <= rd_data;
         irq_o <= (ctrl[CT_RX_IE] & ~rx_empty) | (ctrl[CT_TX_IE] & tx_empty);
         // A same-cycle set beats the software clear so no underflow is lost.
         if (uf_set)      rx_underflow <= 1'b1;
         else if (uf_clr) rx_underflow <= 1'b0;
         if (ctrl_wr) ctrl <= wb_dat_i[1:0];
      end
   end

endmodule

// File: tb/tb_wb_io_fifo.sv
// Self-checking bench for wb_io_fifo: bus scoreboard for acks/read data, TX stream queue.
module tb_wb_io_fifo;
   import wb_io_pkg::*;

   localparam int DW    = 16;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          wb_cyc_i, wb_stb_i, wb_we_i;
   logic [1:0]    wb_adr_i;
   logic [DW-1:0] wb_dat_i;
   logic [DW-1:0] wb_dat_o;
   logic          wb_ack_o, wb_stall_o;
   logic [DW-1:0] tx_data_o;
   logic          tx_valid_o, tx_ready_i;
   logic [DW-1:0] rx_data_i;
   logic          rx_valid_i, rx_ready_o;
   logic          irq_o;

   // {is_read, expected read data} per accepted request, in acceptance order
   logic [DW:0]   exp_q[$];
   logic [DW-1:0] tx_q[$];
   logic [DW:0]   mon_e;
   logic [DW-1:0] mon_t;
   logic          mon_en = 1'b0;
   int            n_checks = 0;
   int            n_pass = 0;

   always #5 clk = ~clk;

   wb_io_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wb_cyc_i   (wb_cyc_i),
      .wb_stb_i   (wb_stb_i),
      .wb_we_i    (wb_we_i),
      .wb_adr_i   (wb_adr_i),
      .wb_dat_i   (wb_dat_i),
      .wb_dat_o   (wb_dat_o),
      .wb_ack_o   (wb_ack_o),
      .wb_stall_o (wb_stall_o),
      .tx_data_o  (tx_data_o),
      .tx_valid_o (tx_valid_o),
      .tx_ready_i (tx_ready_i),
      .rx_data_i  (rx_data_i),
      .rx_valid_i (rx_valid_i),
      .rx_ready_o (rx_ready_o),
      .irq_o      (irq_o)
   );

   // Scoreboard: an accepted request must be acked at the very next sample, nothing else may ack.
   always @(negedge clk) begin
      if (mon_en) begin
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_checks++;
            if (wb_ack_o !== 1'b1) $display("FAIL ack_missing: ack=%b required 1", wb_ack_o);
            else n_pass++;
            if (mon_e[DW]) begin
               n_checks++;
               if (wb_dat_o !== mon_e[DW-1:0])
                  $display("FAIL read_data: got %h required %h", wb_dat_o, mon_e[DW-1:0]);
               else n_pass++;
            end
         end else begin
            n_checks++;
            if (wb_ack_o !== 1'b0) $display("FAIL spurious_ack: ack=%b required 0", wb_ack_o);
            else n_pass++;
         end
         if (tx_valid_o === 1'b1 && tx_ready_i === 1'b1) begin
            n_checks++;
            if (tx_q.size() == 0) $display("FAIL tx_unexpected: got %h required none", tx_data_o);
            else begin
               mon_t = tx_q.pop_front();
               if (tx_data_o !== mon_t) $display("FAIL tx_data: got %h required %h", tx_data_o, mon_t);
               else n_pass++;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
   endtask

   task automatic note_accept(input logic we, input logic [1:0] adr,
                              input logic [DW-1:0] dat, input logic [DW-1:0] exp);
      exp_q.push_back({~we, exp});
      if (we && adr == ADR_DATA) tx_q.push_back(dat);
   endtask

   // Called just after a rising edge; leaves the request asserted for back-to-back use.
   task automatic bus_op(input logic we, input logic [1:0] adr,
                         input logic [DW-1:0] dat, input logic [DW-1:0] exp);
      int budget;
      budget = 40;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wb_we_i  = we;
      wb_adr_i = adr;
      wb_dat_i = dat;
      @(negedge clk);
      while (wb_stall_o && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (budget == 0) begin
         n_checks++;
         $display("FAIL bus_timeout: stall=%b required 0 within budget", wb_stall_o);
         bus_idle();
         #1;
         return;
      end
      @(posedge clk);
      note_accept(we, adr, dat, exp);
      #1;
   endtask

   task automatic rx_push(input logic [DW-1:0] d);
      n_checks++;
      if (rx_ready_o !== 1'b1) $display("FAIL rx_ready_pre: got %b required 1", rx_ready_o);
      else n_pass++;
      rx_valid_i = 1'b1;
      rx_data_i  = d;
      @(posedge clk);
      #1 rx_valid_i = 1'b0;
   endtask

   task automatic drain_tx(input string name);
      int budget;
      budget = 30;
      tx_ready_i = 1'b1;
      while (tx_valid_o && budget > 0) begin
         step(1);
         budget--;
      end
      tx_ready_i = 1'b0;
      n_checks++;
      if (tx_valid_o !== 1'b0 || tx_q.size() != 0)
         $display("FAIL %s: tx_valid=%b left=%0d required 0/0", name, tx_valid_o, tx_q.size());
      else n_pass++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus_idle();
      wb_adr_i = '0; wb_dat_i = '0;
      tx_ready_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = '0;
      @(negedge clk);
      n_checks++;
      if ({wb_ack_o, wb_dat_o, irq_o, tx_valid_o, rx_ready_o} !== {1'b0, 16'h0, 1'b0, 1'b0, 1'b1})
         $display("FAIL reset_values: ack=%b dat=%h irq=%b txv=%b rxr=%b required 0 0000 0 0 1",
                  wb_ack_o, wb_dat_o, irq_o, tx_valid_o, rx_ready_o);
      else n_pass++;
      rst_n = 1'b1;
      step(1);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
      wb_adr_i = ADR_DATA; wb_dat_i = 16'h5555;
      step(1);
      bus_idle();
      n_checks++;
      if (wb_ack_o !== 1'b1 || tx_valid_o !== 1'b1)
         $display("FAIL pre_reset_write: ack=%b txv=%b required 1 1", wb_ack_o, tx_valid_o);
      else n_pass++;
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if (wb_ack_o !== 1'b0 || tx_valid_o !== 1'b0 || rx_ready_o !== 1'b1)
         $display("FAIL async_reset: ack=%b txv=%b rxr=%b required 0 0 1",
                  wb_ack_o, tx_valid_o, rx_ready_o);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      step(1);
      exp_q.delete();
      tx_q.delete();
      mon_en = 1'b1;
      bus_op(1'b0, ADR_STATUS, '0, 16'h000A);
      bus_idle();
      step(1);
   endtask

   task automatic test_tx();
      bus_op(1'b1, ADR_DATA, 16'h1234, '0);
      bus_op(1'b1, ADR_DATA, 16'hBEEF, '0);
      bus_op(1'b0, ADR_COUNT, '0, 16'h0200);
      bus_idle();
      step(1);
      n_checks++;
      if (tx_data_o !== 16'h1234 || tx_valid_o !== 1'b1)
         $display("FAIL tx_head: got %h/%b required 1234/1", tx_data_o, tx_valid_o);
      else n_pass++;
      drain_tx("tx_drain");
   endtask

   task automatic test_back_to_back();
      bus_op(1'b1, ADR_CTRL, 16'hFFFF, '0);
      bus_op(1'b0, ADR_CTRL, '0, 16'h0003);
      bus_op(1'b1, ADR_CTRL, 16'h0000, '0);
      bus_op(1'b0, ADR_CTRL, '0, 16'h0000);
      bus_op(1'b0, ADR_STATUS, '0, 16'h000A);
      bus_op(1'b1, ADR_COUNT, 16'hFFFF, '0);
      bus_op(1'b0, ADR_COUNT, '0, 16'h0000);
      bus_idle();
      step(1);
   endtask

   task automatic test_tx_full();
      for (int i = 0; i < DEPTH; i++) bus_op(1'b1, ADR_DATA, 16'h1000 + 16'(i), '0);
      wb_dat_i = 16'h9999;
      @(negedge clk);
      n_checks++;
      if (wb_stall_o !== 1'b1) $display("FAIL stall_full: got %b required 1", wb_stall_o);
      else n_pass++;
      @(posedge clk);
      #1 tx_ready_i = 1'b1;
      @(negedge clk);
      n_checks++;
      if (wb_stall_o !== 1'b1) $display("FAIL stall_during_pop: got %b required 1", wb_stall_o);
      else n_pass++;
      @(posedge clk);
      #1 tx_ready_i = 1'b0;
      @(negedge clk);
      n_checks++;
      if (wb_stall_o !== 1'b0) $display("FAIL stall_release: got %b required 0", wb_stall_o);
      else n_pass++;
      @(posedge clk);
      note_accept(1'b1, ADR_DATA, 16'h9999, '0);
      #1;
      bus_op(1'b0, ADR_STATUS, '0, 16'h0009);
      bus_op(1'b0, ADR_COUNT, '0, 16'h0800);
      bus_idle();
      step(1);
      drain_tx("tx_full_drain");
   endtask

   task automatic test_rx_underflow();
      rx_push(16'h00A5);
      bus_op(1'b0, ADR_DATA, '0, 16'h00A5);
      bus_op(1'b0, ADR_DATA, '0, 16'h0000);
      bus_op(1'b0, ADR_STATUS, '0, 16'h001A);
      bus_op(1'b1, ADR_STATUS, 16'h0010, '0);
      bus_op(1'b0, ADR_STATUS, '0, 16'h000A);
      bus_idle();
      step(1);
   endtask

   task automatic test_rx_concurrent();
      rx_push(16'h0042);
      rx_valid_i = 1'b1; rx_data_i = 16'h0043;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = ADR_DATA;
      @(posedge clk);
      note_accept(1'b0, ADR_DATA, '0, 16'h0042);
      #1 rx_valid_i = 1'b0;
      bus_op(1'b0, ADR_COUNT, '0, 16'h0001);
      bus_op(1'b0, ADR_DATA, '0, 16'h0043);
      bus_idle();
      step(1);
   endtask

   task automatic test_rx_full();
      for (int i = 0; i < DEPTH; i++) rx_push(16'h0100 + 16'(i));
      n_checks++;
      if (rx_ready_o !== 1'b0) $display("FAIL rx_full_ready: got %b required 0", rx_ready_o);
      else n_pass++;
      bus_op(1'b0, ADR_COUNT, '0, 16'h0008);
      bus_op(1'b0, ADR_STATUS, '0, 16'h0006);
      rx_valid_i = 1'b1; rx_data_i = 16'hDEAD;
      wb_we_i = 1'b0; wb_adr_i = ADR_DATA;
      @(negedge clk);
      n_checks++;
      if (rx_ready_o !== 1'b0) $display("FAIL rx_ready_same_cycle: got %b required 0", rx_ready_o);
      else n_pass++;
      @(posedge clk);
      note_accept(1'b0, ADR_DATA, '0, 16'h0100);
      #1 rx_valid_i = 1'b0;
      bus_idle();
      @(negedge clk);
      n_checks++;
      if (rx_ready_o !== 1'b1) $display("FAIL rx_ready_after_pop: got %b required 1", rx_ready_o);
      else n_pass++;
      @(posedge clk);
      #1;
      for (int i = 1; i < DEPTH; i++) bus_op(1'b0, ADR_DATA, '0, 16'h0100 + 16'(i));
      bus_op(1'b0, ADR_STATUS, '0, 16'h000A);
      bus_idle();
      step(1);
   endtask

   task automatic test_irq();
      bus_op(1'b1, ADR_CTRL, 16'h0001, '0);
      bus_idle();
      step(2);
      n_checks++;
      if (irq_o !== 1'b0) $display("FAIL irq_rx_empty: got %b required 0", irq_o);
      else n_pass++;
      rx_push(16'h0077);
      @(negedge clk);
      n_checks++;
      if (irq_o !== 1'b0) $display("FAIL irq_one_edge: got %b required 0", irq_o);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (irq_o !== 1'b1) $display("FAIL irq_rx_data: got %b required 1", irq_o);
      else n_pass++;
      @(posedge clk);
      #1;
      bus_op(1'b0, ADR_DATA, '0, 16'h0077);
      bus_idle();
      step(2);
      n_checks++;
      if (irq_o !== 1'b0) $display("FAIL irq_rx_drained: got %b required 0", irq_o);
      else n_pass++;
      bus_op(1'b1, ADR_CTRL, 16'h0002, '0);
      bus_idle();
      step(2);
      n_checks++;
      if (irq_o !== 1'b1) $display("FAIL irq_tx_empty: got %b required 1", irq_o);
      else n_pass++;
      bus_op(1'b1, ADR_CTRL, 16'h0000, '0);
      bus_idle();
      step(2);
      n_checks++;
      if (irq_o !== 1'b0) $display("FAIL irq_disabled: got %b required 0", irq_o);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_tx();
      test_back_to_back();
      test_tx_full();
      test_rx_underflow();
      test_rx_concurrent();
      test_rx_full();
      test_irq();
      step(2);
      n_checks++;
      if (exp_q.size() != 0 || tx_q.size() != 0)
         $display("FAIL leftover: bus=%0d tx=%0d required 0/0", exp_q.size(), tx_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
